// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target with byte-wide register file (optional general call: I2C_TGT_GENERAL_CALL_EN)
module i2c_target_regs #(
  parameter logic [6:0] TGT_ADDR = 7'h50,
  parameter int         NUM_REGS = 16,
  parameter logic [7:0] REG_RST  = 8'h00,
  localparam int        AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_o,
  output logic          sda_t,
  input  logic [AW-1:0] loc_addr,
  output logic [7:0]    loc_rdata,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, IGNORE
  } state_t;

  state_t        state, state_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [AW-1:0] ptr, ptr_n;
  logic          busy_n, sda_t_n;
  logic          gc, gc_n;
  logic          reg_we, reg_clr;
  logic [7:0]    regs [NUM_REGS];

  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;
  logic scl_rise, scl_fall, start, stop;
  logic [7:0] byte_in, rd_byte;

  assign sda_o = 1'b0;

  // Two-stage synchronizers plus history flop; reset to the idle-high bus level
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_h <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_h <= 1'b1;
    end else begin
      scl_s1 <= scl_i; scl_s2 <= scl_s1; scl_h <= scl_s2;
      sda_s1 <= sda_i; sda_s2 <= sda_s1; sda_h <= sda_s2;
    end
  end

  assign scl_rise = scl_s2 & ~scl_h;
  assign scl_fall = ~scl_s2 & scl_h;
  assign start    = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop     = scl_s2 & scl_h & ~sda_h & sda_s2;
  assign byte_in  = {shreg[6:0], sda_s2};
  assign rd_byte  = regs[ptr];

  // Protocol state and shift/pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bitcnt <= 3'd0;
      shreg  <= 8'h00;
      ptr    <= '0;
      busy   <= 1'b0;
      sda_t  <= 1'b1;
      gc     <= 1'b0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      ptr    <= ptr_n;
      busy   <= busy_n;
      sda_t  <= sda_t_n;
      gc     <= gc_n;
    end
  end

  // Next-state logic; in the ACK states sda_t itself marks whether the ACK is already being driven
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    ptr_n    = ptr;
    busy_n   = busy;
    sda_t_n  = sda_t;
    gc_n     = gc;
    reg_we   = 1'b0;
    reg_clr  = 1'b0;
    if (start) begin
      state_n  = ADDR;
      bitcnt_n = 3'd0;
      sda_t_n  = 1'b1;
      gc_n     = 1'b0;
    end else if (stop) begin
      state_n  = IDLE;
      busy_n   = 1'b0;
      sda_t_n  = 1'b1;
      gc_n     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        ADDR: begin
          if (scl_rise) begin
            shreg_n  = byte_in;
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              if (byte_in[7:1] == TGT_ADDR) begin
                state_n = ADDR_ACK;
                busy_n  = 1'b1;
              end
`ifdef I2C_TGT_GENERAL_CALL_EN
              else if (byte_in == 8'h00) begin
                state_n = ADDR_ACK;
                busy_n  = 1'b1;
                gc_n    = 1'b1;
              end
`endif
              else begin
                state_n = IGNORE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (sda_t) begin
              sda_t_n = 1'b0;
            end else begin
              bitcnt_n = 3'd0;
              if (shreg[0]) begin
                shreg_n = rd_byte;
                sda_t_n = rd_byte[7];
                state_n = RDATA;
              end else begin
                sda_t_n = 1'b1;
                state_n = PTR;
              end
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            shreg_n  = byte_in;
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              if (gc) begin
                if (byte_in == 8'h06) begin
                  reg_clr = 1'b1;
                  ptr_n   = '0;
                  state_n = PTR_ACK;
                end else begin
                  state_n = IGNORE;
                end
              end else begin
                ptr_n   = byte_in[AW-1:0];
                state_n = PTR_ACK;
              end
            end
          end
        end
        PTR_ACK: begin
          if (scl_fall) begin
            if (sda_t) begin
              sda_t_n = 1'b0;
            end else begin
              sda_t_n  = 1'b1;
              bitcnt_n = 3'd0;
              state_n  = gc ? IGNORE : WDATA;
            end
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shreg_n  = byte_in;
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              reg_we  = 1'b1;
              ptr_n   = ptr + AW'(1);
              state_n = WACK;
            end
          end
        end
        WACK: begin
          if (scl_fall) begin
            if (sda_t) begin
              sda_t_n = 1'b0;
            end else begin
              sda_t_n  = 1'b1;
              bitcnt_n = 3'd0;
              state_n  = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bitcnt == 3'd7) begin
              sda_t_n = 1'b1;
              ptr_n   = ptr + AW'(1);
              state_n = RACK;
            end else begin
              shreg_n  = {shreg[6:0], 1'b0};
              sda_t_n  = shreg[6];
              bitcnt_n = bitcnt + 3'd1;
            end
          end
        end
        RACK: begin
          if (scl_rise && sda_s2) begin
            state_n = IGNORE;
          end else if (scl_fall) begin
            shreg_n  = rd_byte;
            sda_t_n  = rd_byte[7];
            bitcnt_n = 3'd0;
            state_n  = RDATA;
          end
        end
        IGNORE: begin
          sda_t_n = 1'b1;
        end
        default: begin
          state_n = IDLE;
          sda_t_n = 1'b1;
        end
      endcase
    end
  end

  // Register file: I2C byte writes and general-call clear
  always_ff @(posedge clk) begin
    if (rst || reg_clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_RST;
    end else if (reg_we) begin
      regs[ptr] <= byte_in;
    end
  end

  // Write-event report to local logic
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'h00;
    end else begin
      wr_stb <= reg_we;
      if (reg_we) begin
        wr_addr <= ptr;
        wr_data <= byte_in;
      end
    end
  end

  // Local read port, one clk latency; same-cycle write shows up next cycle
  always_ff @(posedge clk) begin
    if (rst) loc_rdata <= REG_RST;
    else     loc_rdata <= regs[loc_addr];
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed bench for i2c_target_regs (general-call checks follow I2C_TGT_GENERAL_CALL_EN)
module tb_i2c_target_regs;

  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_o, sda_t;
  logic [3:0] loc_addr;
  logic [7:0] loc_rdata;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       sda_line;

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [3:0] la [16];
  logic [7:0] ld [16];
  logic       ack;
  logic [7:0] d;

  assign sda_line = sda_m & (sda_t | sda_o);

  i2c_target_regs dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line),
    .sda_o(sda_o), .sda_t(sda_t), .loc_addr(loc_addr), .loc_rdata(loc_rdata),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Log every write strobe
  always @(negedge clk) begin
    if (wr_stb && n < 16) begin
      la[n] = wr_addr;
      ld[n] = wr_data;
      n = n + 1;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      sda_m = b[7-i]; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    send_bits(b, 8);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    a = ~sda_line; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic read_byte(output logic [7:0] v, input logic mack);
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      v[7-i] = sda_line; #Q;
      scl_m = 1'b0; #Q;
    end
    sda_m = ~mack; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
    sda_m = 1'b1;
  endtask

  task automatic rd_reg(input logic [3:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk) loc_addr = a;
    @(negedge clk);
    @(negedge clk);
    check(tag, loc_rdata, exp);
  endtask

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; loc_addr = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sda_t", {7'd0, sda_t}, 8'h01);
    check("rst_sda_o", {7'd0, sda_o}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_wr_stb", {7'd0, wr_stb}, 8'h00);
    check("rst_wr_addr", {4'd0, wr_addr}, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_loc_rdata", loc_rdata, 8'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Write burst
    i2c_start();
    send_byte(8'hA0, ack); check("wb_ack_addr", {7'd0, ack}, 8'h01);
    check("wb_busy", {7'd0, busy}, 8'h01);
    send_byte(8'h03, ack); check("wb_ack_ptr", {7'd0, ack}, 8'h01);
    send_byte(8'h5A, ack); check("wb_ack_d0", {7'd0, ack}, 8'h01);
    send_byte(8'hC3, ack); check("wb_ack_d1", {7'd0, ack}, 8'h01);
    i2c_stop();
    #Q;
    check("wb_busy_after_stop", {7'd0, busy}, 8'h00);
    check("wb_stb_count", n[7:0], 8'd2);
    check("wb_stb0_addr", {4'd0, la[0]}, 8'h03);
    check("wb_stb0_data", ld[0], 8'h5A);
    check("wb_stb1_addr", {4'd0, la[1]}, 8'h04);
    check("wb_stb1_data", ld[1], 8'hC3);
    rd_reg(4'd4, 8'hC3, "wb_reg4");
    rd_reg(4'd3, 8'h5A, "wb_reg3");

    // Seed reg[5] so the post-read pointer can be observed
    i2c_start();
    send_byte(8'hA0, ack); send_byte(8'h05, ack); send_byte(8'h77, ack);
    i2c_stop();
    check("seed_stb_data", ld[2], 8'h77);

    // Read with repeated START
    i2c_start();
    send_byte(8'hA0, ack); send_byte(8'h03, ack);
    i2c_start();
    send_byte(8'hA1, ack); check("rd_ack_addr", {7'd0, ack}, 8'h01);
    read_byte(d, 1'b1); check("rd_byte0", d, 8'h5A);
    read_byte(d, 1'b0); check("rd_byte1", d, 8'hC3);
    #Q;
    check("rd_released_after_nack", {7'd0, sda_t}, 8'h01);
    i2c_stop();
    i2c_start();
    send_byte(8'hA1, ack);
    read_byte(d, 1'b0); check("rd_ptr_is_5", d, 8'h77);
    i2c_stop();
    check("rd_no_stb", n[7:0], 8'd3);

    // Address mismatch
    i2c_start();
    send_byte(8'hA2, ack); check("mm_nack_addr", {7'd0, ack}, 8'h00);
    send_byte(8'h11, ack); check("mm_nack_data", {7'd0, ack}, 8'h00);
    check("mm_busy", {7'd0, busy}, 8'h00);
    i2c_stop();
    check("mm_no_stb", n[7:0], 8'd3);
    rd_reg(4'd3, 8'h5A, "mm_reg3");

    // Pointer wrap and pointer upper-bit discard
    i2c_start();
    send_byte(8'hA0, ack); send_byte(8'h0F, ack);
    send_byte(8'h11, ack); send_byte(8'h22, ack);
    i2c_stop();
    rd_reg(4'd15, 8'h11, "wrap_reg15");
    rd_reg(4'd0, 8'h22, "wrap_reg0");
    check("wrap_stb4_addr", {4'd0, la[4]}, 8'h00);
    i2c_start();
    send_byte(8'hA0, ack); send_byte(8'h13, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    read_byte(d, 1'b0); check("ptr_0x13_reads_reg3", d, 8'h5A);
    i2c_stop();

    // STOP after half a data byte
    i2c_start();
    send_byte(8'hA0, ack); send_byte(8'h07, ack);
    send_bits(8'hF0, 4);
    i2c_stop();
    check("abort_no_stb", n[7:0], 8'd5);
    rd_reg(4'd7, 8'h00, "abort_reg7");

    // Reset while driving a 0 data bit
    i2c_start();
    send_byte(8'hA0, ack); send_byte(8'h03, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    check("rdata_driving_low", {7'd0, sda_t}, 8'h00);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("rst_mid_release", {7'd0, sda_t}, 8'h01);
    check("rst_mid_busy", {7'd0, busy}, 8'h00);
    rd_reg(4'd3, 8'h00, "rst_mid_reg3");
    rd_reg(4'd15, 8'h00, "rst_mid_reg15");
    i2c_stop();
    i2c_start();
    send_byte(8'hA0, ack); check("recover_ack", {7'd0, ack}, 8'h01);
    send_byte(8'h02, ack); send_byte(8'h99, ack);
    i2c_stop();
    rd_reg(4'd2, 8'h99, "recover_reg2");
    check("recover_stb_addr", {4'd0, la[5]}, 8'h02);

    // General call
    i2c_start();
    send_byte(8'h00, ack);
`ifdef I2C_TGT_GENERAL_CALL_EN
    check("gc_ack_addr", {7'd0, ack}, 8'h01);
    send_byte(8'h06, ack); check("gc_ack_cmd", {7'd0, ack}, 8'h01);
    i2c_stop();
    rd_reg(4'd2, 8'h00, "gc_reg2");
    check("gc_no_stb", n[7:0], 8'd6);
`else
    check("gc_off_nack", {7'd0, ack}, 8'h00);
    i2c_stop();
    rd_reg(4'd2, 8'h99, "gc_off_reg2");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
